// File: rtl/mnist_batch_sequencer.sv
// Batch controller for the serial MNIST classifier: streams each image from the pixel ROM,
// waits for the prediction (or a timeout), scores it against the label ROM and counts hits.
module mnist_batch_sequencer #(
    parameter int IMG_PIXELS = 784,
    parameter int NUM_IMAGES = 1000,
    parameter int ADDR_W     = 20,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic              pix_rd_data,
    output logic [9:0]        lbl_addr,
    input  logic [3:0]        lbl_rd_data,
    output logic              cls_data_in,
    output logic              cls_valid_in,
    input  logic [3:0]        cls_prediction,
    input  logic              cls_valid_out,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [3:0]        result_pred,
    output logic              result_correct,
    output logic [10:0]       hit_count
);

    localparam int PIX_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT, S_SCORE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              pix_rd_en_q, pix_rd_en_d;
    logic              cls_valid_q, cls_valid_d;
    logic [9:0]        img_idx_q, img_idx_d;
    logic [3:0]        label_q, label_d;
    logic [TMO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              result_valid_q, result_valid_d;
    logic [3:0]        result_pred_q, result_pred_d;
    logic              result_correct_q, result_correct_d;
    logic [10:0]       hit_count_q, hit_count_d;
    logic              pred_hit;

    always_comb begin
        state_d          = state_q;
        pix_cnt_d        = pix_cnt_q;
        base_d           = base_q;
        pix_addr_d       = pix_addr_q;
        pix_rd_en_d      = pix_rd_en_q;
        cls_valid_d      = pix_rd_en_q;
        img_idx_d        = img_idx_q;
        label_d          = label_q;
        wait_cnt_d       = wait_cnt_q;
        result_valid_d   = 1'b0;
        result_pred_d    = result_pred_q;
        result_correct_d = result_correct_q;
        hit_count_d      = hit_count_q;
        pred_hit         = (cls_prediction == label_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_STREAM;
                    hit_count_d = '0;
                    img_idx_d   = '0;
                    base_d      = '0;
                    pix_addr_d  = '0;
                    pix_cnt_d   = '0;
                    pix_rd_en_d = 1'b1;
                end
            end
            S_STREAM: begin
                // Label ROM has settled by the last stream cycle since IMG_PIXELS >= 2
                label_d = lbl_rd_data;
                if (pix_cnt_q == PIX_W'(IMG_PIXELS - 1)) begin
                    state_d     = S_WAIT;
                    pix_rd_en_d = 1'b0;
                    base_d      = base_q + ADDR_W'(IMG_PIXELS);
                    wait_cnt_d  = '0;
                end else begin
                    pix_cnt_d  = pix_cnt_q + PIX_W'(1);
                    pix_addr_d = pix_addr_q + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                if (cls_valid_out) begin
                    state_d          = S_SCORE;
                    result_valid_d   = 1'b1;
                    result_pred_d    = cls_prediction;
                    result_correct_d = pred_hit;
                    hit_count_d      = hit_count_q + 11'(pred_hit);
                end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d          = S_SCORE;
                    result_valid_d   = 1'b1;
                    result_pred_d    = 4'hF;
                    result_correct_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
                end
            end
            S_SCORE: begin
                if (img_idx_q == 10'(NUM_IMAGES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d     = S_STREAM;
                    img_idx_d   = img_idx_q + 10'd1;
                    pix_addr_d  = base_q;
                    pix_cnt_d   = '0;
                    pix_rd_en_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, drops the pixel still in flight, keeps the score
        if (abort) begin
            state_d          = S_IDLE;
            pix_rd_en_d      = 1'b0;
            cls_valid_d      = 1'b0;
            result_valid_d   = 1'b0;
            result_pred_d    = result_pred_q;
            result_correct_d = result_correct_q;
            hit_count_d      = hit_count_q;
        end

        busy_d = (state_d == S_STREAM) || (state_d == S_WAIT) || (state_d == S_SCORE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            pix_cnt_q        <= '0;
            base_q           <= '0;
            pix_addr_q       <= '0;
            pix_rd_en_q      <= 1'b0;
            cls_valid_q      <= 1'b0;
            img_idx_q        <= '0;
            label_q          <= '0;
            wait_cnt_q       <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            result_valid_q   <= 1'b0;
            result_pred_q    <= '0;
            result_correct_q <= 1'b0;
            hit_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            pix_cnt_q        <= pix_cnt_d;
            base_q           <= base_d;
            pix_addr_q       <= pix_addr_d;
            pix_rd_en_q      <= pix_rd_en_d;
            cls_valid_q      <= cls_valid_d;
            img_idx_q        <= img_idx_d;
            label_q          <= label_d;
            wait_cnt_q       <= wait_cnt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            result_valid_q   <= result_valid_d;
            result_pred_q    <= result_pred_d;
            result_correct_q <= result_correct_d;
            hit_count_q      <= hit_count_d;
        end
    end

    // The ROM's one-cycle read latency is the pixel delay; the valid is delayed to match it
    assign cls_valid_in   = cls_valid_q;
    assign cls_data_in    = cls_valid_q & pix_rd_data;
    assign pix_rd_en      = pix_rd_en_q;
    assign pix_addr       = pix_addr_q;
    assign lbl_addr       = img_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result_valid   = result_valid_q;
    assign result_pred    = result_pred_q;
    assign result_correct = result_correct_q;
    assign hit_count      = hit_count_q;

endmodule

// File: doc/mnist_batch_sequencer.md
Name:
mnist_batch_sequencer

Overview:
- Hardware batch-evaluation controller in front of the serial-input MNIST classifier (`top`: `data_in`/`valid_in` in, `prediction`/`valid_out` out).
- Reads binarised images, one bit per pixel, from a pixel ROM and streams each image as a contiguous burst of IMG_PIXELS bits, then waits for the classification.
- Scores each classification against a label ROM, counts hits, and walks NUM_IMAGES images with no testbench involvement.

Parameters:
- IMG_PIXELS, 784: bits per image; must be ≥ 2.
- NUM_IMAGES, 1000: images per batch; must be ≥ 1.
- ADDR_W, 20: pixel ROM address width; must satisfy 2^ADDR_W ≥ IMG_PIXELS*NUM_IMAGES.
- TIMEOUT, 4096: maximum WAIT cycles before an image is declared a miss.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a batch from IDLE or DONE; ignored while busy.
- abort  in  1  synchronous; returns the block to IDLE on the next edge.
- pix_rd_en  out  1  pixel ROM read strobe.
- pix_addr  out  ADDR_W  pixel ROM address; read data returns exactly 1 cycle later.
- pix_rd_data  in  1  pixel bit.
- lbl_addr  out  10  label ROM address; equals the current image index.
- lbl_rd_data  in  4  expected digit; valid 1 cycle after lbl_addr changes.
- cls_data_in  out  1  pixel bit to the classifier.
- cls_valid_in  out  1  pixel-valid strobe to the classifier.
- cls_prediction  in  4  classifier result.
- cls_valid_out  in  1  classifier result strobe.
- busy  out  1  high in STREAM, WAIT and SCORE.
- done  out  1  high in DONE.
- result_valid  out  1  one-cycle pulse per scored image.
- result_pred  out  4  scored prediction; 4'hF on timeout.
- result_correct  out  1  prediction matched the label.
- hit_count  out  11  correct predictions in the current batch.

Behaviour:
- Reset: all outputs 0; state IDLE; image index 0; address base register 0.
- FSM states: IDLE, STREAM, WAIT, SCORE, DONE.
- IDLE/DONE → STREAM on start:
  - clear hit_count, image index and base.
  - done drops in the same edge.
- STREAM: pix_rd_en=1 for exactly IMG_PIXELS consecutive cycles, with pix_addr = base, base+1, …, base+IMG_PIXELS-1.
  - base advances by IMG_PIXELS per image using an adder; no multiplier.
- Read-to-classifier timing: cls_valid_in and cls_data_in are pix_rd_en and pix_rd_data delayed 1 cycle.
  - Result: IMG_PIXELS contiguous valid cycles per image, with no gaps.
  - The last valid cycle falls in the first WAIT cycle.
- STREAM → WAIT the cycle after the last address is issued.
- Label capture: the label is registered internally during STREAM.
- cls_valid_out outside WAIT is ignored.
- WAIT → SCORE on cls_valid_out:
  - latch cls_prediction.
  - correct = (prediction == label).
- WAIT → SCORE on timeout: after TIMEOUT WAIT cycles with no cls_valid_out.
  - prediction = 4'hF, correct = 0.
  - A cls_valid_out arriving on the timeout cycle itself wins over the timeout.
- SCORE (1 cycle):
  - result_valid=1.
  - hit_count += correct.
  - result_pred/result_correct are held until the next SCORE.
- SCORE → DONE if image index == NUM_IMAGES-1.
- SCORE → STREAM otherwise: image index +1, with no idle cycle between images.
- DONE: done=1, busy=0; hit_count is held until the next start.
- abort: takes priority over all transitions, including a simultaneous start.
  - Next state IDLE; pix_rd_en/cls_valid_in are 0 from the following cycle.
  - An in-flight delayed pixel is dropped.
  - hit_count is retained.
- rst mid-batch: same effect as abort, but also clears hit_count and the result registers.

Test Plan:
- Timing (IMG_PIXELS=4, NUM_IMAGES=3, TIMEOUT=16), start at cycle 10:
  - pix_addr 0,1,2,3 in cycles 11-14.
  - cls_valid_in high in cycles 12-15, with cls_data_in matching ROM bits 0-3.
  - image 1 addresses are 4-7; image 2 addresses are 8-11.
- Scoring: labels {3,7,1}, model answers {3,2,1} each 5 cycles after the last valid:
  - three result_valid pulses with result_correct 1,0,1.
  - hit_count=2 and done=1.
- Timeout: model never asserts cls_valid_out for image 1:
  - after 16 WAIT cycles, result_pred=4'hF and result_correct=0.
  - image 2 streams next; final hit_count counts only matches.
- Simultaneous events (both checked):
  - cls_valid_out on exactly the 16th WAIT cycle → the prediction is scored, not a timeout.
  - cls_valid_out during STREAM → ignored, no result_valid.
- abort during STREAM at pixel 2:
  - cls_valid_in is 0 within 1 cycle; busy=0; hit_count unchanged.
  - a subsequent start restarts at pix_addr 0.
- start pulse while busy has no effect; start in DONE clears hit_count to 0 and reruns the batch.
